// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt/trap sequencer.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IRQ     = 2'd1,
    EXC     = 2'd2,
    IRQ_EXC = 2'd3
  } irq_state_t;

  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
  localparam int          MIE_IRQ_OFFSET = 16;

  // mcause value reported for platform interrupt line idx.
  function automatic logic [31:0] irq_cause(input logic [4:0] idx);
    return IRQ_CAUSE_BASE + {27'd0, idx};
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority (lowest index wins) encoder; the one-hot output doubles as the ack vector.
module irq_priority_encoder #(
  parameter  int IRQ_NUM = 16,
  localparam int SEL_W   = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1
) (
  input  logic [IRQ_NUM-1:0] masked,
  output logic               any,
  output logic [SEL_W-1:0]   sel,
  output logic [IRQ_NUM-1:0] onehot
);

  assign any = |masked;

  // Isolates the lowest set bit.
  assign onehot = masked & (~masked + IRQ_NUM'(1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (masked[i]) sel = SEL_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode trap sequencer: edge-latched interrupts, exception arbitration and
// handler-nesting tracking in front of the CSR block.
module irq_controller
  import irq_pkg::*;
#(
  parameter int IRQ_NUM = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               exception_i,
  input  logic [31:0]        exc_cause_i,
  input  logic               mret_i,
  output logic               trap_o,
  output logic [31:0]        mcause_o,
  output logic [IRQ_NUM-1:0] irq_ack_o,
  output logic               irq_ret_o,
  output logic [1:0]         state_o
);

  localparam int SEL_W = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

  irq_state_t         state_q, state_d;
  logic [IRQ_NUM-1:0] irq_req_q, pending_q, rise, masked, onehot;
  logic [SEL_W-1:0]   sel;
  logic               any, take, ret_q;
  logic               unused_mie;

  assign unused_mie = ^mie_i;

  assign rise   = irq_req_i & ~irq_req_q;
  assign masked = pending_q & mie_i[MIE_IRQ_OFFSET +: IRQ_NUM];

  irq_priority_encoder #(.IRQ_NUM(IRQ_NUM)) u_prio (
    .masked (masked),
    .any    (any),
    .sel    (sel),
    .onehot (onehot)
  );

  // ret_q holds off a new take for one cycle after returning from an interrupt handler.
  assign take = (state_q == IDLE) && !exception_i && !mret_i && any && !ret_q;

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (exception_i) begin
      case (state_q)
        IDLE:    state_d = EXC;
        IRQ:     state_d = IRQ_EXC;
        default: state_d = state_q;
      endcase
    end else if (mret_i) begin
      case (state_q)
        IRQ:     state_d = IDLE;
        EXC:     state_d = IDLE;
        IRQ_EXC: state_d = IRQ;
        default: state_d = state_q;
      endcase
    end else if (take) begin
      state_d = IRQ;
    end
  end

  always_comb begin
    trap_o    = 1'b0;
    mcause_o  = '0;
    irq_ack_o = '0;
    irq_ret_o = 1'b0;
    if (!rst_i) begin
      if (exception_i) begin
        trap_o   = 1'b1;
        mcause_o = exc_cause_i;
      end else if (mret_i) begin
        irq_ret_o = (state_q == IRQ);
      end else if (take) begin
        trap_o    = 1'b1;
        mcause_o  = irq_cause(5'(sel));
        irq_ack_o = onehot;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_req_q <= '0;
      pending_q <= '0;
      ret_q     <= 1'b0;
    end else begin
      irq_req_q <= irq_req_i;
      // A fresh rise on the line being acked re-sets its pending bit.
      pending_q <= (pending_q & ~irq_ack_o) | rise;
      ret_q     <= irq_ret_o;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a nesting-stack reference model.
module tb_irq_controller;

  localparam logic [1:0] S_IDLE = 2'd0, S_IRQ = 2'd1, S_EXC = 2'd2, S_IRQ_EXC = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] irq_req_i;
  logic [31:0] mie_i;
  logic        exception_i;
  logic [31:0] exc_cause_i;
  logic        mret_i;
  logic        trap_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ack_o;
  logic        irq_ret_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  int ack4_cnt = 0;

  always #5 clk_i = ~clk_i;

  irq_controller #(.IRQ_NUM(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .exception_i (exception_i),
    .exc_cause_i (exc_cause_i),
    .mret_i      (mret_i),
    .trap_o      (trap_o),
    .mcause_o    (mcause_o),
    .irq_ack_o   (irq_ack_o),
    .irq_ret_o   (irq_ret_o),
    .state_o     (state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pending bits, previous request sample, and a stack of
  // active handlers (0 = interrupt, 1 = exception). gap blocks the cycle after an irq return.
  logic [15:0] m_pend = '0;
  logic [15:0] m_prev = '0;
  bit          m_stack[$];
  bit          m_gap = 1'b0;

  function automatic logic [1:0] m_state();
    if (m_stack.size() == 0) return S_IDLE;
    if (m_stack.size() == 2) return S_IRQ_EXC;
    return m_stack[0] ? S_EXC : S_IRQ;
  endfunction

  // Compare DUT outputs against the model for the current inputs, then advance one clock.
  task automatic step();
    logic        e_trap, e_ret;
    logic [31:0] e_cause;
    logic [15:0] e_ack;
    e_trap = 1'b0; e_ret = 1'b0; e_cause = '0; e_ack = '0;
    if (!rst_i) begin
      if (exception_i) begin
        e_trap  = 1'b1;
        e_cause = exc_cause_i;
      end else if (mret_i) begin
        e_ret = (m_stack.size() == 1) && !m_stack[0];
      end else if (m_stack.size() == 0 && !m_gap) begin
        for (int k = 0; k < 16; k++) begin
          if (!e_trap && m_pend[k] && mie_i[16+k]) begin
            e_trap  = 1'b1;
            e_cause = 32'h8000_0010 + k;
            e_ack   = 16'(1 << k);
          end
        end
      end
    end
    check("trap_o",    {31'd0, trap_o},    {31'd0, e_trap});
    check("mcause_o",  mcause_o,           e_cause);
    check("irq_ack_o", {16'd0, irq_ack_o}, {16'd0, e_ack});
    check("irq_ret_o", {31'd0, irq_ret_o}, {31'd0, e_ret});
    check("state_o",   {30'd0, state_o},   {30'd0, m_state()});
    if (irq_ack_o[4] === 1'b1) ack4_cnt++;

    if (rst_i) begin
      m_pend = '0; m_prev = '0; m_stack.delete(); m_gap = 1'b0;
    end else begin
      m_pend = (m_pend & ~e_ack) | (irq_req_i & ~m_prev);
      m_prev = irq_req_i;
      if (exception_i) begin
        if (m_stack.size() == 0 || !m_stack[m_stack.size()-1]) m_stack.push_back(1'b1);
      end else if (mret_i) begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
      end else if (e_ack != 0) begin
        m_stack.push_back(1'b0);
      end
      m_gap = e_ret;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r, input logic [15:0] req, input logic [31:0] mie,
                       input logic exc, input logic [31:0] cause, input logic mret);
    rst_i = r; irq_req_i = req; mie_i = mie;
    exception_i = exc; exc_cause_i = cause; mret_i = mret;
    #2;
  endtask

  task automatic cyc(input logic r, input logic [15:0] req, input logic [31:0] mie,
                     input logic exc, input logic [31:0] cause, input logic mret);
    drive(r, req, mie, exc, cause, mret);
    step();
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [31:0] mie;
    logic        exc;
    logic [31:0] cause;
    logic        mret;
    logic        trap;
    logic [31:0] mcause;
    logic [15:0] ack;
    logic        ret;
    logic [1:0]  state;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] req, input logic [31:0] mie, input logic exc,
                              input logic [31:0] cause, input logic mret, input logic trap,
                              input logic [31:0] mcause, input logic [15:0] ack,
                              input logic ret, input logic [1:0] state);
    vec_t v;
    v.rst = 1'b0; v.req = req; v.mie = mie; v.exc = exc; v.cause = cause; v.mret = mret;
    v.trap = trap; v.mcause = mcause; v.ack = ack; v.ret = ret; v.state = state;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    logic [15:0] rq;
    vecs[0]  = mk(16'h0001, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);
    vecs[1]  = mk(16'h0001, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0010,  16'h0001, 1'b0, S_IDLE);
    vecs[2]  = mk(16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          16'h0000, 1'b1, S_IRQ);
    vecs[3]  = mk(16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);
    vecs[4]  = mk(16'h002A, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);
    vecs[5]  = mk(16'h002A, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0013,  16'h0008, 1'b0, S_IDLE);
    vecs[6]  = mk(16'h002A, 32'h0028_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          16'h0000, 1'b1, S_IRQ);
    vecs[7]  = mk(16'h002A, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);
    vecs[8]  = mk(16'h002A, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0015,  16'h0020, 1'b0, S_IDLE);
    vecs[9]  = mk(16'h002A, 32'h0028_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          16'h0000, 1'b1, S_IRQ);
    vecs[10] = mk(16'h002A, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);
    vecs[11] = mk(16'h002A, 32'h002A_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0011,  16'h0002, 1'b0, S_IDLE);
    vecs[12] = mk(16'h002A, 32'h002A_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          16'h0000, 1'b1, S_IRQ);
    vecs[13] = mk(16'h002A, 32'h002A_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);
    vecs[14] = mk(16'h0004, 32'h0004_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);
    vecs[15] = mk(16'h0004, 32'h0004_0000, 1'b1, 32'h2, 1'b0, 1'b1, 32'h0000_0002,  16'h0000, 1'b0, S_IDLE);
    vecs[16] = mk(16'h0004, 32'h0004_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          16'h0000, 1'b0, S_EXC);
    vecs[17] = mk(16'h0004, 32'h0004_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0012,  16'h0004, 1'b0, S_IDLE);
    vecs[18] = mk(16'h0004, 32'h0004_0000, 1'b1, 32'hB, 1'b0, 1'b1, 32'h0000_000B,  16'h0000, 1'b0, S_IRQ);
    vecs[19] = mk(16'h0004, 32'h0004_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          16'h0000, 1'b0, S_IRQ_EXC);
    vecs[20] = mk(16'h0004, 32'h0004_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          16'h0000, 1'b1, S_IRQ);
    vecs[21] = mk(16'h0000, 32'h0004_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          16'h0000, 1'b0, S_IDLE);

    // Power-up reset: the first edge only clears the X state, then reset is checked.
    drive(1'b1, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("reset_trap", {31'd0, trap_o}, 32'd0);
    check("reset_ack",  {16'd0, irq_ack_o}, 32'd0);
    @(posedge clk_i);
    #1;
    cyc(1'b1, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 16'hFFFF, 32'hFFFF_FFFF, 1'b1, 32'h5, 1'b1);
    check("reset_mcause", mcause_o, 32'd0);
    check("reset_state",  {30'd0, state_o}, {30'd0, S_IDLE});
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].mie, vecs[i].exc, vecs[i].cause, vecs[i].mret);
      check($sformatf("tbl%0d_trap", i),   {31'd0, trap_o},    {31'd0, vecs[i].trap});
      check($sformatf("tbl%0d_mcause", i), mcause_o,           vecs[i].mcause);
      check($sformatf("tbl%0d_ack", i),    {16'd0, irq_ack_o}, {16'd0, vecs[i].ack});
      check($sformatf("tbl%0d_ret", i),    {31'd0, irq_ret_o}, {31'd0, vecs[i].ret});
      check($sformatf("tbl%0d_state", i),  {30'd0, state_o},   {30'd0, vecs[i].state});
      step();
    end

    // Level-held line during a handler, then a rise coincident with its ack.
    cyc(1'b0, 16'h0001, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h0001, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    ack4_cnt = 0;
    repeat (10) cyc(1'b0, 16'h0011, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h0000, 32'h0011_0000, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 16'h0000, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h0010, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    check("held_line_one_trap", ack4_cnt, 1);
    cyc(1'b0, 16'h0010, 32'h0011_0000, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 16'h0010, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h0010, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h0000, 32'h0011_0000, 1'b0, 32'h0, 1'b1);
    repeat (4) cyc(1'b0, 16'h0000, 32'h0011_0000, 1'b0, 32'h0, 1'b0);
    check("coincident_rise_second_trap", ack4_cnt, 2);

    // Reset in IRQ_EXC with lines 4..7 pending.
    cyc(1'b0, 16'h0001, 32'h00FF_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h0001, 32'h00FF_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h00F1, 32'h00FF_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 16'h00F1, 32'h00FF_0000, 1'b1, 32'h7, 1'b0);
    check("pre_reset_state", {30'd0, state_o}, {30'd0, S_IRQ_EXC});
    cyc(1'b1, 16'h0000, 32'h00FF_0000, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 16'h0000, 32'h00FF_0000, 1'b0, 32'h0, 1'b0);
    repeat (3) begin
      drive(1'b0, 16'h0000, 32'h00FF_0000, 1'b0, 32'h0, 1'b0);
      check("post_reset_no_trap", {31'd0, trap_o}, 32'd0);
      check("post_reset_state", {30'd0, state_o}, {30'd0, S_IDLE});
      step();
    end
    drive(1'b0, 16'h0000, 32'h00FF_0000, 1'b0, 32'h0, 1'b1);
    check("idle_mret_no_ret", {31'd0, irq_ret_o}, 32'd0);
    step();

    // Randomized traffic against the model.
    rq = '0;
    for (int n = 0; n < 600; n++) begin
      rq = rq ^ 16'($urandom & $urandom & $urandom);
      cyc(($urandom_range(0, 63) == 0), rq, $urandom, ($urandom_range(0, 7) == 0),
          $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
